// File: rtl/gate_fault_monitor.sv
// rtl/gate_fault_monitor.sv - debounced over-threshold trip / hysteretic release gate interlock
// Optional stale-data watchdog enabled by defining FAULT_MON_WDOG_EN.
module gate_fault_monitor #(
    parameter int ADC_WIDTH     = 8,
    parameter int TRIP_COUNT    = 3,
    parameter int RELEASE_COUNT = 4,
    parameter int WDOG_CYCLES   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_WIDTH-1:0] ave_data_in,
    input  logic                 data_in_valid,
    input  logic [ADC_WIDTH-1:0] trip_thresh,
    input  logic [ADC_WIDTH-1:0] release_thresh,
    input  logic                 fault_clear,
    output logic                 gate_en,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic                 trip_pulse,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_PEND     = 3'd2,
        ST_TRIP     = 3'd3,
        ST_WAIT_CLR = 3'd4
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;

    generate
        if (TRIP_COUNT < 1 || TRIP_COUNT > 15 || RELEASE_COUNT < 1 ||
            RELEASE_COUNT > 15 || WDOG_CYCLES < 2) begin : g_bad_param
            $error("gate_fault_monitor: parameter out of range");
        end
    endgenerate

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_gate_en;
    logic       r_fault;
    logic [1:0] r_fault_code;
    logic       r_trip_pulse;

    logic       w_hi;
    logic       w_lo;
    logic [3:0] w_cnt_inc;

    assign w_hi      = ave_data_in >= trip_thresh;
    // Requiring both compares keeps a misordered release level from releasing above trip.
    assign w_lo      = (ave_data_in < release_thresh) && (ave_data_in < trip_thresh);
    assign w_cnt_inc = (r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1;

`ifdef FAULT_MON_WDOG_EN
    localparam int            WDOG_W   = $clog2(WDOG_CYCLES) + 1;
    localparam logic [1:0]    CODE_STALE = 2'b10;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] r_wdog;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= 4'd0;
            r_gate_en    <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= CODE_NONE;
            r_trip_pulse <= 1'b0;
`ifdef FAULT_MON_WDOG_EN
            r_wdog       <= '0;
`endif
        end else begin
            r_trip_pulse <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (data_in_valid) begin
                        if (w_hi) begin
                            r_state      <= ST_TRIP;
                            r_fault      <= 1'b1;
                            r_fault_code <= CODE_OVER;
                            r_trip_pulse <= 1'b1;
                            r_cnt        <= 4'd0;
                        end else begin
                            r_state   <= ST_RUN;
                            r_gate_en <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (data_in_valid && w_hi) begin
                        if (TRIP_COUNT == 1) begin
                            r_state      <= ST_TRIP;
                            r_gate_en    <= 1'b0;
                            r_fault      <= 1'b1;
                            r_fault_code <= CODE_OVER;
                            r_trip_pulse <= 1'b1;
                            r_cnt        <= 4'd0;
                        end else begin
                            r_state <= ST_PEND;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                ST_PEND: begin
                    if (data_in_valid) begin
                        if (!w_hi) begin
                            r_state <= ST_RUN;
                            r_cnt   <= 4'd0;
                        end else if (w_cnt_inc == 4'(TRIP_COUNT)) begin
                            r_state      <= ST_TRIP;
                            r_gate_en    <= 1'b0;
                            r_fault      <= 1'b1;
                            r_fault_code <= CODE_OVER;
                            r_trip_pulse <= 1'b1;
                            r_cnt        <= 4'd0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_TRIP: begin
                    if (data_in_valid) begin
                        if (!w_lo) begin
                            r_cnt <= 4'd0;
                        end else if (w_cnt_inc == 4'(RELEASE_COUNT)) begin
                            r_state <= ST_WAIT_CLR;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_WAIT_CLR: begin
                    if (data_in_valid && w_hi) begin
                        r_state      <= ST_TRIP;
                        r_fault_code <= CODE_OVER;
                        r_trip_pulse <= 1'b1;
                        r_cnt        <= 4'd0;
                    end else if (fault_clear) begin
                        r_state      <= ST_RUN;
                        r_gate_en    <= 1'b1;
                        r_fault      <= 1'b0;
                        r_fault_code <= CODE_NONE;
                        r_cnt        <= 4'd0;
                    end
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_gate_en <= 1'b0;
                    r_fault   <= 1'b0;
                    r_cnt     <= 4'd0;
                end
            endcase
`ifdef FAULT_MON_WDOG_EN
            // Only fires when no sample arrives, so it never competes with the case above.
            if (r_state == ST_RUN || r_state == ST_PEND) begin
                if (data_in_valid) begin
                    r_wdog <= '0;
                end else if (r_wdog == WDOG_LAST) begin
                    r_wdog       <= '0;
                    r_state      <= ST_TRIP;
                    r_gate_en    <= 1'b0;
                    r_fault      <= 1'b1;
                    r_fault_code <= CODE_STALE;
                    r_trip_pulse <= 1'b1;
                    r_cnt        <= 4'd0;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

    assign gate_en    = r_gate_en;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign trip_pulse = r_trip_pulse;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_gate_fault_monitor.sv
// tb/tb_gate_fault_monitor.sv - directed scoreboard bench for gate_fault_monitor
module tb_gate_fault_monitor;

    typedef struct packed {
        logic       g;
        logic       f;
        logic [1:0] c;
        logic       p;
        logic [2:0] s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ave_data_in = 8'd0;
    logic       data_in_valid = 1'b0;
    logic [7:0] trip_thresh = 8'd200;
    logic [7:0] release_thresh = 8'd180;
    logic       fault_clear = 1'b0;
    logic       gate_en;
    logic       fault;
    logic [1:0] fault_code;
    logic       trip_pulse;
    logic [2:0] state_dbg;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gate_fault_monitor #(
        .ADC_WIDTH    (8),
        .TRIP_COUNT   (3),
        .RELEASE_COUNT(4),
        .WDOG_CYCLES  (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ave_data_in   (ave_data_in),
        .data_in_valid (data_in_valid),
        .trip_thresh   (trip_thresh),
        .release_thresh(release_thresh),
        .fault_clear   (fault_clear),
        .gate_en       (gate_en),
        .fault         (fault),
        .fault_code    (fault_code),
        .trip_pulse    (trip_pulse),
        .state_dbg     (state_dbg)
    );

    function automatic exp_t mk(input logic g, input logic f, input logic [1:0] c,
                                input logic p, input logic [2:0] s);
        exp_t e;
        e.g = g; e.f = f; e.c = c; e.p = p; e.s = s;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".gate_en"},    {2'b00, gate_en},    {2'b00, e.g});
            chk({tag, ".fault"},      {2'b00, fault},      {2'b00, e.f});
            chk({tag, ".fault_code"}, {1'b0, fault_code},  {1'b0, e.c});
            chk({tag, ".trip_pulse"}, {2'b00, trip_pulse}, {2'b00, e.p});
            chk({tag, ".state"},      state_dbg,           e.s);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic c, input exp_t e);
        data_in_valid = v;
        ave_data_in   = d;
        fault_clear   = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        exp_t e_init, e_run, e_pend, e_trip_p, e_trip, e_wait;
        e_init   = mk(1'b0, 1'b0, 2'b00, 1'b0, 3'd0);
        e_run    = mk(1'b1, 1'b0, 2'b00, 1'b0, 3'd1);
        e_pend   = mk(1'b1, 1'b0, 2'b00, 1'b0, 3'd2);
        e_trip_p = mk(1'b0, 1'b1, 2'b01, 1'b1, 3'd3);
        e_trip   = mk(1'b0, 1'b1, 2'b01, 1'b0, 3'd3);
        e_wait   = mk(1'b0, 1'b1, 2'b01, 1'b0, 3'd4);

        repeat (2) @(posedge clk);
        #1;
        sb.push_back(e_init);
        compare("reset");
        rst = 1'b0;

        step("idle_init", 1'b0, 8'd0,   1'b0, e_init);
        step("init_run",  1'b1, 8'd100, 1'b0, e_run);
        step("pend1",     1'b1, 8'd210, 1'b0, e_pend);
        step("pend2",     1'b1, 8'd210, 1'b0, e_pend);
        step("break_run", 1'b1, 8'd150, 1'b0, e_run);
        step("pend1b",    1'b1, 8'd210, 1'b0, e_pend);
        step("pend2b",    1'b1, 8'd200, 1'b0, e_pend);
        step("trip",      1'b1, 8'd210, 1'b0, e_trip_p);
        step("trip_hold", 1'b0, 8'd0,   1'b0, e_trip);

        step("rel1",      1'b1, 8'd170, 1'b1, e_trip);
        step("rel2",      1'b1, 8'd170, 1'b1, e_trip);
        step("rel_break", 1'b1, 8'd190, 1'b1, e_trip);
        step("rel3",      1'b1, 8'd170, 1'b1, e_trip);
        step("rel4",      1'b1, 8'd170, 1'b1, e_trip);
        step("rel5",      1'b1, 8'd170, 1'b1, e_trip);
        step("rel_wait",  1'b1, 8'd170, 1'b1, e_wait);
        step("clr_run",   1'b0, 8'd0,   1'b1, e_run);

        step("t2_pend1",  1'b1, 8'd210, 1'b0, e_pend);
        step("t2_pend2",  1'b1, 8'd210, 1'b0, e_pend);
        step("t2_trip",   1'b1, 8'd210, 1'b0, e_trip_p);
        step("t2_r180",   1'b1, 8'd180, 1'b0, e_trip);
        for (int i = 0; i < 3; i++)
            step($sformatf("t2_rel%0d", i), 1'b1, 8'd170, 1'b0, e_trip);
        step("t2_wait",   1'b1, 8'd170, 1'b0, e_wait);
        step("t2_noclr",  1'b0, 8'd0,   1'b0, e_wait);
        step("clr_vs_hi", 1'b1, 8'd220, 1'b1, e_trip_p);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("r_run",   1'b1, 8'd100, 1'b0, e_run);
        step("r_pend1", 1'b1, 8'd210, 1'b0, e_pend);
        step("r_pend2", 1'b1, 8'd210, 1'b0, e_pend);
        rst = 1'b1;
        #1;
        sb.push_back(e_init);
        compare("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("init_trip",  1'b1, 8'd210, 1'b0, e_trip_p);
        step("init_trip2", 1'b0, 8'd0,   1'b0, e_trip);

`ifdef FAULT_MON_WDOG_EN
        for (int i = 0; i < 3; i++)
            step($sformatf("w_rel%0d", i), 1'b1, 8'd170, 1'b0, e_trip);
        step("w_wait", 1'b1, 8'd170, 1'b0, e_wait);
        step("w_run",  1'b0, 8'd0,   1'b1, e_run);
        for (int i = 1; i < 64; i++)
            step($sformatf("w_quiet%0d", i), 1'b0, 8'd0, 1'b0, e_run);
        step("w_expire", 1'b0, 8'd0, 1'b0, mk(1'b0, 1'b1, 2'b10, 1'b1, 3'd3));
        for (int i = 0; i < 3; i++)
            step($sformatf("w_rel2_%0d", i), 1'b1, 8'd170, 1'b0,
                 mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd3));
        step("w_wait2", 1'b1, 8'd170, 1'b0, mk(1'b0, 1'b1, 2'b10, 1'b0, 3'd4));
        step("w_run2",  1'b0, 8'd0,   1'b1, e_run);
        for (int i = 1; i < 64; i++)
            step($sformatf("w_q2_%0d", i), 1'b0, 8'd0, 1'b0, e_run);
        step("w_save", 1'b1, 8'd100, 1'b0, e_run);
        for (int i = 1; i < 64; i++)
            step($sformatf("w_q3_%0d", i), 1'b0, 8'd0, 1'b0, e_run);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_fault_monitor.md
Name: gate_fault_monitor

Overview:
- Consumes the decimated average stream from the box-average low-pass stage (average word plus single-cycle valid pulse).
- Applies debounced over-threshold trip and hysteretic release to that stream, and drives the gate-enable interlock for the gate driver.
- Trips are latched and require an explicit clear.
- An optional watchdog trips the driver if the average stream stops arriving.

Parameters:
- ADC_WIDTH, 8, width of the averaged sample word; matches the upstream averager.
- TRIP_COUNT, 3, consecutive valid samples >= trip_thresh needed to trip (1..15).
- RELEASE_COUNT, 4, consecutive valid samples below release level needed before clear is accepted (1..15).
- WDOG_CYCLES, 4096, clk cycles without data_in_valid before stale-data trip (optional feature only; >= 2).

Ports:
- clk  in  1  sample-rate clock, same as the averager.
- rst  in  1  asynchronous active-high reset.
- ave_data_in  in  ADC_WIDTH  averaged sample from the averager.
- data_in_valid  in  1  single-cycle pulse; ave_data_in is valid this cycle.
- trip_thresh  in  ADC_WIDTH  trip level, unsigned; held static during operation.
- release_thresh  in  ADC_WIDTH  release level, unsigned.
- fault_clear  in  1  level; request return to RUN.
- gate_en  out  1  registered; 1 = gate driver permitted to switch.
- fault  out  1  registered; latched fault indicator.
- fault_code  out  2  registered; 00 none, 01 over-threshold, 10 stale data, 11 unused.
- trip_pulse  out  1  registered; one-cycle pulse on every entry to TRIP.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset: while rst is high, and asynchronously on assertion, the block is forced to:
  - state INIT; gate_en=0, fault=0, fault_code=00, trip_pulse=0.
  - Debounce counter = 0; watchdog counter = 0.
  - Reset mid-operation (any state) behaves identically.
- Compare definitions, unsigned, ADC_WIDTH bits, no extension:
  - hi = ave_data_in >= trip_thresh.
  - lo = (ave_data_in < release_thresh) && (ave_data_in < trip_thresh). A misordered release_thresh therefore never releases above trip.
- Inputs other than rst are evaluated only on clk edges. Compares are evaluated only when data_in_valid=1.
- Latency: all outputs are registered. A valid sample at edge N is reflected in outputs after edge N+1, i.e. one cycle.
- State INIT (gate_en=0, fault=0): on valid, !hi -> RUN; hi -> TRIP with code 01.
- State RUN (gate_en=1): on valid & hi, TRIP_COUNT==1 -> TRIP (code 01); otherwise -> PEND with cnt=1.
- State PEND (gate_en=1):
  - valid & hi: cnt+1; when cnt+1 == TRIP_COUNT -> TRIP (code 01).
  - valid & !hi -> RUN, cnt=0. A non-consecutive run never trips.
- State TRIP (gate_en=0, fault=1):
  - Entry sets trip_pulse for exactly one cycle and clears cnt.
  - valid & lo: cnt+1; when cnt+1 == RELEASE_COUNT -> WAIT_CLR.
  - valid & !lo: cnt=0.
  - fault_clear is ignored.
- State WAIT_CLR (gate_en=0, fault=1, fault_code held):
  - valid & hi -> TRIP (new trip_pulse, code 01).
  - Else fault_clear=1 -> RUN: fault=0, code=00, cnt=0, watchdog=0.
  - Simultaneous fault_clear with a valid hi sample: the trip wins.
- The debounce counter is 4 bits and saturating; it never wraps.
- fault_code is updated only on TRIP entry. It is cleared only on WAIT_CLR->RUN or reset.

Optional Feature:
- Macro: FAULT_MON_WDOG_EN.
- Defined:
  - A counter of width clog2(WDOG_CYCLES)+1 increments each clk in RUN/PEND and resets to 0 on data_in_valid.
  - Reaching WDOG_CYCLES-1 with no valid that cycle -> TRIP with code 10.
  - A valid in the same cycle as expiry wins and resets the counter.
  - The counter is held at 0 in INIT, TRIP and WAIT_CLR.
- Undefined: no watchdog logic; fault_code never equals 10.

Test Plan (ADC_WIDTH=8, trip_thresh=200, release_thresh=180, TRIP_COUNT=3, RELEASE_COUNT=4):
- Reset, then valid sample 100 -> gate_en=1 one cycle after the valid; fault=0, state RUN.
- From RUN, valid samples 210,210,150,210,210,210 -> no trip through the fifth; one cycle after the sixth, trip_pulse=1 for one cycle, gate_en=0, fault=1, fault_code=01.
- In TRIP, samples 170,170,190,170,170,170,170 with fault_clear held high throughout -> stays TRIP until after the seventh sample, then WAIT_CLR, then RUN the next cycle; gate_en=1, fault=0, fault_code=00.
- In WAIT_CLR, fault_clear=1 and valid sample 220 in the same cycle -> TRIP, trip_pulse=1, gate_en stays 0.
- With FAULT_MON_WDOG_EN and WDOG_CYCLES=64, in RUN issue no valid for 64 cycles -> TRIP, fault_code=10. Repeat with a valid on cycle 63 -> no trip.
- Assert rst mid-PEND (cnt=2) -> outputs go to reset values immediately (asynchronously). After release, a sample of 210 -> TRIP (hi from INIT goes directly to TRIP, code 01).
